// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and helpers for the instruction-fetch stage.
//               Holds the fetch FSM state encoding and the FIFO level-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch sequencer states. mem_en is asserted in REQ and DROP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int fetch_level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with push, pop, synchronous clear, level
//               output and a registered-state head output. DEPTH must be a
//               power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [WIDTH-1:0]   i_data,
  output logic [WIDTH-1:0]   o_head,
  output logic [LEVEL_W-1:0] o_level
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [LEVEL_W-1:0] r_count;
  logic               w_pop;
  logic               w_push;

  // Pop from empty is a no-op; a push into a full FIFO only lands if a pop
  // frees a slot in the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != LEVEL_W'(DEPTH)) || w_pop);

  // Storage write; a clear cycle discards any coincident push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; clear overrides push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + LEVEL_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - LEVEL_W'(1);
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_stage
// Description : Instruction-fetch front end. Issues sequential reads over an
//               enable/ack handshake, buffers returned words in a prefetch
//               FIFO and hands them downstream on a DOR/ack interface.
//               Redirect flushes the buffer and restarts at a new PC; a read
//               already in flight is allowed to finish and is discarded.
//               Optional macro FETCH_PC_TAG_EN adds a parallel PC FIFO and
//               the data_out_pc port.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         mem_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_do,
  input  logic                         mem_do_ack,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         DOR,
  input  logic                         ack_to_fetch,
  output logic [DATA_W-1:0]            data_out,
`ifdef FETCH_PC_TAG_EN
  output logic [ADDR_W-1:0]            data_out_pc,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int c_LEVEL_W = fetch_level_w(DEPTH);

  fetch_state_t         r_state;
  fetch_state_t         w_state_nxt;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_pc_nxt;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [ADDR_W-1:0]    w_addr_nxt;
  logic [ADDR_W-1:0]    w_pc_inc;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_clear;
  logic                 w_room;
  logic [c_LEVEL_W:0]   w_post_level;
  logic [c_LEVEL_W-1:0] w_level;

  // Redirect flushes the FIFO in the same edge, so it suppresses any pop.
  assign w_pop        = DOR && ack_to_fetch && !redirect;
  assign w_room       = (w_level < c_LEVEL_W'(DEPTH));
  assign w_pc_inc     = r_pc + ADDR_W'(1);
  // Occupancy after the current push together with any coincident pop.
  assign w_post_level = {1'b0, w_level} + (c_LEVEL_W+1)'(1) - (c_LEVEL_W+1)'(w_pop);

  // State, PC and request-address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_mem_addr <= w_addr_nxt;
    end
  end

  // Next-state logic: issue gating, push on ack, redirect flush/drop handling.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_mem_addr;
    w_push      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect) begin
          w_clear  = 1'b1;
          w_pc_nxt = redirect_pc;
        end else if (w_room) begin
          w_state_nxt = REQ;
          w_addr_nxt  = r_pc;
        end
      end
      REQ: begin
        if (redirect) begin
          // The in-flight read must complete; its address stays on the bus.
          w_clear     = 1'b1;
          w_pc_nxt    = redirect_pc;
          w_state_nxt = mem_do_ack ? IDLE : DROP;
        end else if (mem_do_ack) begin
          w_push     = 1'b1;
          w_pc_nxt   = w_pc_inc;
          w_addr_nxt = w_pc_inc;
          if (w_post_level >= (c_LEVEL_W+1)'(DEPTH)) begin
            w_state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          w_clear  = 1'b1;
          w_pc_nxt = redirect_pc;
        end
        if (mem_do_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign mem_en   = (r_state != IDLE);
  assign mem_addr = r_mem_addr;
  assign DOR      = (w_level != '0);
  assign level    = w_level;

  fetch_fifo #(
    .WIDTH   (DATA_W),
    .DEPTH   (DEPTH),
    .LEVEL_W (c_LEVEL_W)
  ) u_data_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (mem_do),
    .o_head  (data_out),
    .o_level (w_level)
  );

`ifdef FETCH_PC_TAG_EN
  // Mirrors the data FIFO exactly, so its level always matches w_level.
  logic [c_LEVEL_W-1:0] w_pc_level_unused;

  fetch_fifo #(
    .WIDTH   (ADDR_W),
    .DEPTH   (DEPTH),
    .LEVEL_W (c_LEVEL_W)
  ) u_pc_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_pc),
    .o_head  (data_out_pc),
    .o_level (w_pc_level_unused)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_stage
// Description : Scoreboard bench for fetch_prefetch_stage. The stimulus
//               process loads the expected word stream; a monitor pops and
//               compares on every downstream handshake. Memory returns
//               word(a) = a*37+11 for address a.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_stage;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] pc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       mem_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_do;
  logic       mem_do_ack;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       DOR;
  logic       ack_to_fetch;
  logic [7:0] data_out;
`ifdef FETCH_PC_TAG_EN
  logic [7:0] data_out_pc;
`endif
  logic [2:0] level;

  int   n_checks;
  int   n_fail;
  int   n_delivered;
  int   mem_lat;
  bit   mem_stall;
  int   wait_cnt;
  exp_t exp_q[$];

  fetch_prefetch_stage #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .DEPTH    (4),
    .RESET_PC (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_do       (mem_do),
    .mem_do_ack   (mem_do_ack),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .DOR          (DOR),
    .ack_to_fetch (ack_to_fetch),
    .data_out     (data_out),
`ifdef FETCH_PC_TAG_EN
    .data_out_pc  (data_out_pc),
`endif
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] word_at(input logic [7:0] a);
    logic [7:0] r;
    r = a * 8'd37 + 8'd11;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_stream(input logic [7:0] start, input int n);
    logic [7:0] a;
    exp_t       e;
    exp_q.delete();
    a = start;
    for (int i = 0; i < n; i++) begin
      e.data = word_at(a);
      e.pc   = a;
      exp_q.push_back(e);
      a = a + 8'd1;
    end
  endtask

  // Memory model: acks after mem_lat idle cycles unless stalled.
  always @(negedge clk) begin
    if (mem_en && !mem_stall && wait_cnt >= mem_lat) begin
      mem_do_ack = 1'b1;
      mem_do     = word_at(mem_addr);
      wait_cnt   = 0;
    end else begin
      mem_do_ack = 1'b0;
      if (mem_en) wait_cnt = wait_cnt + 1;
      else        wait_cnt = 0;
    end
  end

  // Monitor: every downstream handshake must match the head of the stream.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (!rst && DOR && ack_to_fetch && !redirect) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %0h, expected no word at %0t", data_out, $time);
      end else begin
        e = exp_q.pop_front();
        n_delivered++;
        if (data_out !== e.data) begin
          n_fail++;
          $display("FAIL data_out: got %0h, expected %0h at %0t", data_out, e.data, $time);
        end
`ifdef FETCH_PC_TAG_EN
        n_checks++;
        if (data_out_pc !== e.pc) begin
          n_fail++;
          $display("FAIL data_out_pc: got %0h, expected %0h at %0t", data_out_pc, e.pc, $time);
        end
`endif
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    n_checks = 0; n_fail = 0; n_delivered = 0;
    rst = 1'b1; ack_to_fetch = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    mem_lat = 0; mem_stall = 1'b0; wait_cnt = 0;
    mem_do = 8'h00; mem_do_ack = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mem_en",   32'(mem_en),   32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h00);
    check("rst_dor",      32'(DOR),      32'd0);
    check("rst_level",    32'(level),    32'd0);
    check("rst_data_out", 32'(data_out), 32'h00);

    // Streaming: ack every cycle, consumer always accepting
    load_stream(8'h00, 64);
    ack_to_fetch = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("first_mem_en",   32'(mem_en),   32'd1);
    check("first_mem_addr", 32'(mem_addr), 32'h00);
    check("first_dor",      32'(DOR),      32'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("stream_dor", 32'(DOR), 32'd1);
    end

    // Fill with consumer stalled: four reads then idle
    rst = 1'b1; ack_to_fetch = 1'b0;
    load_stream(8'h00, 64);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("full_mem_en",   32'(mem_en),   32'd0);
    check("full_level",    32'(level),    32'd4);
    check("full_dor",      32'(DOR),      32'd1);
    check("full_data_out", 32'(data_out), 32'(word_at(8'h00)));
    ack_to_fetch = 1'b1;
    @(negedge clk);
    ack_to_fetch = 1'b0;
    check("pop1_level",  32'(level),  32'd3);
    check("pop1_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    check("refill_mem_en",   32'(mem_en),   32'd1);
    check("refill_mem_addr", 32'(mem_addr), 32'h04);
    @(negedge clk);
    check("refill_done_mem_en", 32'(mem_en), 32'd0);
    check("refill_done_level",  32'(level),  32'd4);

    // Reset while a read is outstanding with level 3
    ack_to_fetch = 1'b1; mem_stall = 1'b1;
    @(negedge clk);
    ack_to_fetch = 1'b0;
    check("pre_rst_level", 32'(level), 32'd3);
    @(negedge clk);
    check("pre_rst_mem_en",  32'(mem_en), 32'd1);
    check("pre_rst_level3",  32'(level),  32'd3);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_mem_en", 32'(mem_en), 32'd0);
    check("async_rst_dor",    32'(DOR),    32'd0);
    check("async_rst_level",  32'(level),  32'd0);
    load_stream(8'h00, 64);
    @(negedge clk);
    rst = 1'b0; mem_stall = 1'b0; ack_to_fetch = 1'b1;
    @(negedge clk);
    check("refetch_mem_en",   32'(mem_en),   32'd1);
    check("refetch_mem_addr", 32'(mem_addr), 32'h00);
    repeat (10) @(negedge clk);

    // Redirect while a slow read is pending: read is dropped
    rst = 1'b1; mem_lat = 3; exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("drop_req_mem_en",   32'(mem_en),   32'd1);
    check("drop_req_mem_addr", 32'(mem_addr), 32'h00);
    redirect = 1'b1; redirect_pc = 8'h40;
    load_stream(8'h40, 64);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      redirect = 1'b0;
      check("drop_mem_en",   32'(mem_en),   32'd1);
      check("drop_mem_addr", 32'(mem_addr), 32'h00);
      check("drop_dor",      32'(DOR),      32'd0);
    end
    @(negedge clk);
    check("drop_done_mem_en", 32'(mem_en), 32'd0);
    check("drop_done_dor",    32'(DOR),    32'd0);
    @(negedge clk);
    check("redir_mem_en",   32'(mem_en),   32'd1);
    check("redir_mem_addr", 32'(mem_addr), 32'h40);
    repeat (20) @(negedge clk);

    // Redirect coinciding with ack while two words are buffered
    rst = 1'b1; mem_lat = 0; ack_to_fetch = 1'b0; exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("coinc_level_before", 32'(level),      32'd2);
    check("coinc_ack",          32'(mem_do_ack), 32'd1);
    redirect = 1'b1; redirect_pc = 8'h80;
    load_stream(8'h80, 64);
    @(negedge clk);
    redirect = 1'b0;
    check("coinc_level_after", 32'(level),  32'd0);
    check("coinc_dor",         32'(DOR),    32'd0);
    check("coinc_mem_en",      32'(mem_en), 32'd0);
    @(negedge clk);
    check("coinc_next_mem_en",   32'(mem_en),   32'd1);
    check("coinc_next_mem_addr", 32'(mem_addr), 32'h80);
    ack_to_fetch = 1'b1;
    repeat (10) @(negedge clk);

    // PC wrap: 0xFF is followed by 0x00
    redirect = 1'b1; redirect_pc = 8'hFD;
    load_stream(8'hFD, 64);
    @(negedge clk);
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_en && mem_addr == 8'hFF) found = 1'b1;
    end
    check("wrap_seen_ff", 32'(found), 32'd1);
    @(negedge clk);
    check("wrap_mem_en",   32'(mem_en),   32'd1);
    check("wrap_mem_addr", 32'(mem_addr), 32'h00);
    repeat (8) @(negedge clk);

    check("delivered_enough", 32'(n_delivered >= 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
